// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths,
// instruction class encodings and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

    localparam int INSTR_WIDTH_DEF = 20;
    localparam int ADDR_BITS_DEF   = 5;

    typedef enum logic [1:0] {
        CLS_HALT  = 2'b00,
        CLS_ALU   = 2'b01,
        CLS_LOAD  = 2'b10,
        CLS_STORE = 2'b11
    } instr_cls_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FETCH   = 2'b01,
        ST_PRESENT = 2'b10,
        ST_HALT    = 2'b11
    } fetch_state_e;

    function automatic logic is_halt(input logic [1:0] cls);
        return cls == CLS_HALT;
    endfunction

endpackage

// File: rtl/instr_store.sv
// Instruction store: synchronous write port, registered read port.
// A read and write to the same address on one edge returns the new word.
module instr_store #(
    parameter int WIDTH      = 20,
    parameter int DEPTH_BITS = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_BITS-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // write-first so a program word loaded on the start edge is the one fetched
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: program counter, fetch FSM and instruction register
// feeding the CPU over a valid/ready handshake; stops on a HALT word.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// FETCH   | store word at pc arriving from the read port
// PRESENT | instr valid, held until the CPU accepts it
// HALT    | HALT word reached, waiting for start
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int ADDR_BITS   = ADDR_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [ADDR_BITS-1:0]   prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [ADDR_BITS-1:0]   pc,
    output logic                   halted
);

    fetch_state_e           state;
    fetch_state_e           state_nxt;
    logic [ADDR_BITS-1:0]   rd_addr;
    logic [INSTR_WIDTH-1:0] rd_data;
    logic                   store_we;
    logic                   word_is_halt;

    assign store_we     = prog_we && ((state == ST_IDLE) || (state == ST_HALT));
    assign word_is_halt = is_halt(rd_data[INSTR_WIDTH-1 -: 2]);

    instr_store #(
        .WIDTH      (INSTR_WIDTH),
        .DEPTH_BITS (ADDR_BITS)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Read address tracks the pc of the next cycle so the word is ready in FETCH.
    always_comb begin
        state_nxt = state;
        rd_addr   = pc;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    rd_addr   = '0;
                end
            end
            ST_FETCH: begin
                state_nxt = word_is_halt ? ST_HALT : ST_PRESENT;
            end
            ST_PRESENT: begin
                if (instr_ready) begin
                    state_nxt = ST_FETCH;
                    rd_addr   = pc + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc     <= '0;
                        halted <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    instr <= rd_data;
                    if (word_is_halt) begin
                        halted <= 1'b1;
                    end else begin
                        instr_valid <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: reset, straight-line
// program, stalls, pc wrap-around, ignored writes/start, async reset.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [19:0] prog_data;
    logic [19:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [4:0] a, input logic [19:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_halted_clr", {31'd0, halted}, 32'd0);
        chk("start_pc", {27'd0, pc}, 32'd0);
    endtask

    // Waits (bounded) for the next presented word; one FETCH cycle is expected.
    task automatic wait_word(input logic [19:0] exp_instr, input logic [4:0] exp_pc);
        int n = 0;
        while (instr_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("valid_latency", n, 32'd1);
        chk("instr", {12'd0, instr}, {12'd0, exp_instr});
        chk("pc", {27'd0, pc}, {27'd0, exp_pc});
    endtask

    task automatic accept_word(input int stall, input logic hold_ready);
        logic [19:0] i0;
        logic [4:0]  p0;
        i0 = instr;
        p0 = pc;
        instr_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", {12'd0, instr}, {12'd0, i0});
            chk("stall_pc", {27'd0, pc}, {27'd0, p0});
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = hold_ready;
        chk("valid_drop", {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic wait_halt(input logic [4:0] exp_pc);
        int n = 0;
        while (halted !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("halt_latency", n, 32'd1);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_pc", {27'd0, pc}, {27'd0, exp_pc});
    endtask

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        instr_ready = 1'b0;
        tick();
        tick();
        chk("rst_instr", {12'd0, instr}, 32'd0);
        rst = 1'b1;

        // 1: idle after reset
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_valid", {31'd0, instr_valid}, 32'd0);
            chk("idle_pc", {27'd0, pc}, 32'd0);
            chk("idle_halted", {31'd0, halted}, 32'd0);
        end

        // 2: straight-line program, ready held high
        load(5'd0, 20'h47000);
        load(5'd1, 20'h53000);
        load(5'd2, 20'h72001);
        load(5'd3, 20'h00000);
        instr_ready = 1'b1;
        pulse_start();
        wait_word(20'h47000, 5'd0);
        accept_word(0, 1'b1);
        wait_word(20'h53000, 5'd1);
        accept_word(0, 1'b1);
        wait_word(20'h72001, 5'd2);
        accept_word(0, 1'b1);
        wait_halt(5'd3);

        // 3: same program with 3-cycle stalls
        instr_ready = 1'b0;
        pulse_start();
        wait_word(20'h47000, 5'd0);
        accept_word(3, 1'b0);
        wait_word(20'h53000, 5'd1);
        accept_word(3, 1'b0);
        wait_word(20'h72001, 5'd2);
        accept_word(3, 1'b0);
        wait_halt(5'd3);

        // 4: no HALT in store, pc wraps from 31 to 0; then 6: reset while valid
        for (int a = 0; a < 32; a++) load(a[4:0], 20'h40000 | 20'(a));
        instr_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 34; i++) begin
            wait_word(20'h40000 | 20'(i % 32), 5'(i % 32));
            if (i < 33) accept_word(0, 1'b1);
        end
        instr_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_pc", {27'd0, pc}, 32'd0);
        chk("arst_instr", {12'd0, instr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("arst_idle_valid", {31'd0, instr_valid}, 32'd0);

        // write and start on the same edge: new word 0 is fetched
        load(5'd2, 20'h00000);
        prog_we   = 1'b1;
        prog_addr = 5'd0;
        prog_data = 20'h9ABCD;
        pulse_start();
        prog_we   = 1'b0;
        wait_word(20'h9ABCD, 5'd0);

        // 5: write and start while presenting are ignored
        prog_we   = 1'b1;
        prog_addr = 5'd1;
        prog_data = 20'hFFFFF;
        start     = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        chk("ign_valid", {31'd0, instr_valid}, 32'd1);
        chk("ign_pc", {27'd0, pc}, 32'd0);
        chk("ign_instr", {12'd0, instr}, 32'h9ABCD);
        accept_word(1, 1'b0);
        wait_word(20'h40001, 5'd1);
        accept_word(0, 1'b0);
        wait_halt(5'd2);
        pulse_start();
        wait_word(20'h9ABCD, 5'd0);
        accept_word(0, 1'b0);
        wait_word(20'h40001, 5'd1);
        accept_word(0, 1'b0);
        wait_halt(5'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
